// File: rtl/ysyx_220066_lsu_pkg.sv
// Shared definitions for the load/store unit: MemOp encodings, FSM states,
// default bus timeout and the access-size decode used by the lane logic.
package ysyx_220066_lsu_pkg;

   // Load encodings
   localparam logic [2:0] OP_LB  = 3'b000;
   localparam logic [2:0] OP_LH  = 3'b001;
   localparam logic [2:0] OP_LW  = 3'b010;
   localparam logic [2:0] OP_LD  = 3'b011;
   localparam logic [2:0] OP_LBU = 3'b100;
   localparam logic [2:0] OP_LHU = 3'b101;
   localparam logic [2:0] OP_LWU = 3'b110;

   // Store encodings; every other value is sd
   localparam logic [2:0] OP_SB  = 3'b000;
   localparam logic [2:0] OP_SH  = 3'b001;
   localparam logic [2:0] OP_SW  = 3'b010;

   localparam int TIMEOUT_CYC_DEF = 1023;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   // log2 of the access size in bytes: 0 byte, 1 half, 2 word, 3 double
   function automatic logic [1:0] acc_size(input logic wr, input logic [2:0] op);
      if (wr) begin
         case (op)
            OP_SB:   acc_size = 2'd0;
            OP_SH:   acc_size = 2'd1;
            OP_SW:   acc_size = 2'd2;
            default: acc_size = 2'd3;
         endcase
      end else begin
         acc_size = op[1:0];
      end
   endfunction

endpackage

// File: rtl/ysyx_220066_lsu_align.sv
// Combinational lane logic: store data replication and byte mask, load
// lane extraction with sign/zero extension, and misalignment detect.
// Misalignment is only reported when YSYX_220066_LSU_MISALIGN_EN is defined;
// otherwise lanes come from the truncated address bits.
module ysyx_220066_lsu_align
   import ysyx_220066_lsu_pkg::*;
(
   input  logic        st_wr,
   input  logic [2:0]  st_op,
   input  logic [2:0]  st_off,
   input  logic [63:0] st_data_in,
   output logic [63:0] st_data,
   output logic [7:0]  st_mask,
   output logic        misalign,
   input  logic [2:0]  ld_op,
   input  logic [2:0]  ld_off,
   input  logic [63:0] ld_raw,
   output logic [63:0] ld_data
);

   logic [1:0]  sz;
   logic [7:0]  b_lane;
   logic [15:0] h_lane;
   logic [31:0] w_lane;

   assign sz     = acc_size(st_wr, st_op);
   assign b_lane = 8'(ld_raw >> {ld_off, 3'b000});
   assign h_lane = 16'(ld_raw >> {ld_off[2:1], 4'b0000});
   assign w_lane = 32'(ld_raw >> {ld_off[2], 5'b00000});

   // Replicate store data across all lanes and enable only the addressed bytes
   always_comb begin
      st_data = st_data_in;
      st_mask = 8'hFF;
      case (sz)
         2'd0: begin
            st_data = {8{st_data_in[7:0]}};
            st_mask = 8'h01 << st_off;
         end
         2'd1: begin
            st_data = {4{st_data_in[15:0]}};
            st_mask = 8'h03 << {st_off[2:1], 1'b0};
         end
         2'd2: begin
            st_data = {2{st_data_in[31:0]}};
            st_mask = st_off[2] ? 8'hF0 : 8'h0F;
         end
         default: begin
            st_data = st_data_in;
            st_mask = 8'hFF;
         end
      endcase
   end

   // Pick the addressed lane out of the doubleword and extend it
   always_comb begin
      ld_data = ld_raw;
      case (ld_op)
         OP_LB:   ld_data = {{56{b_lane[7]}}, b_lane};
         OP_LH:   ld_data = {{48{h_lane[15]}}, h_lane};
         OP_LW:   ld_data = {{32{w_lane[31]}}, w_lane};
         OP_LBU:  ld_data = {56'd0, b_lane};
         OP_LHU:  ld_data = {48'd0, h_lane};
         OP_LWU:  ld_data = {32'd0, w_lane};
         default: ld_data = ld_raw;
      endcase
   end

`ifdef YSYX_220066_LSU_MISALIGN_EN
   // Half/word/double accesses must be naturally aligned
   always_comb begin
      misalign = 1'b0;
      case (sz)
         2'd1:    misalign = st_off[0];
         2'd2:    misalign = |st_off[1:0];
         2'd3:    misalign = |st_off;
         default: misalign = 1'b0;
      endcase
   end
`else
   assign misalign = 1'b0;
`endif

endmodule

// File: rtl/ysyx_220066_lsu.sv
// Load/store unit: accepts one core request at a time, issues it on a
// valid/ready data bus, waits (with timeout) for the bus response and returns
// a one-cycle response. Optional alignment check: YSYX_220066_LSU_MISALIGN_EN.
module ysyx_220066_lsu
   import ysyx_220066_lsu_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wr,
   input  logic [63:0] req_addr,
   input  logic [2:0]  req_op,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_req_wr,
   output logic [63:0] mem_req_addr,
   output logic [63:0] mem_req_wdata,
   output logic [7:0]  mem_req_wmask,
   input  logic        mem_resp_valid,
   input  logic [63:0] mem_resp_rdata,
   input  logic        mem_resp_err
);

   // Last WAIT cycle index before the timeout response is forced
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

   state_t      state;
   logic        cap_wr;
   logic [2:0]  cap_op;
   logic [2:0]  cap_off;
   logic [31:0] cnt;
   logic [63:0] st_data;
   logic [7:0]  st_mask;
   logic        misalign;
   logic [63:0] ld_data;

   // Store lanes are built from the live request, load lanes from the
   // captured op/offset against the incoming bus data
   ysyx_220066_lsu_align u_align (
      .st_wr      (req_wr),
      .st_op      (req_op),
      .st_off     (req_addr[2:0]),
      .st_data_in (req_wdata),
      .st_data    (st_data),
      .st_mask    (st_mask),
      .misalign   (misalign),
      .ld_op      (cap_op),
      .ld_off     (cap_off),
      .ld_raw     (mem_resp_rdata),
      .ld_data    (ld_data)
   );

   // Transaction FSM with registered core and bus outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= S_IDLE;
         req_ready     <= 1'b1;
         resp_valid    <= 1'b0;
         resp_err      <= 1'b0;
         resp_rdata    <= '0;
         mem_req_valid <= 1'b0;
         mem_req_wr    <= 1'b0;
         mem_req_addr  <= '0;
         mem_req_wdata <= '0;
         mem_req_wmask <= '0;
         cap_wr        <= 1'b0;
         cap_op        <= '0;
         cap_off       <= '0;
         cnt           <= '0;
      end else begin
         // Response outputs are single-cycle pulses; rdata stays 0 otherwise
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  cap_wr    <= req_wr;
                  cap_op    <= req_op;
                  cap_off   <= req_addr[2:0];
                  req_ready <= 1'b0;
                  if (misalign) begin
                     // Rejected locally: no bus traffic at all
                     state      <= S_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else begin
                     state         <= S_ISSUE;
                     mem_req_valid <= 1'b1;
                     mem_req_wr    <= req_wr;
                     mem_req_addr  <= {req_addr[63:3], 3'b000};
                     mem_req_wdata <= req_wr ? st_data : 64'd0;
                     mem_req_wmask <= req_wr ? st_mask : 8'h00;
                  end
               end
            end
            S_ISSUE: begin
               if (mem_req_ready) begin
                  state         <= S_WAIT;
                  cnt           <= '0;
                  mem_req_valid <= 1'b0;
                  mem_req_wr    <= 1'b0;
                  mem_req_addr  <= '0;
                  mem_req_wdata <= '0;
                  mem_req_wmask <= '0;
               end
            end
            S_WAIT: begin
               if (mem_resp_valid) begin
                  state      <= S_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= mem_resp_err;
                  resp_rdata <= (mem_resp_err || cap_wr) ? 64'd0 : ld_data;
               end else if (cnt == TO_LAST) begin
                  state      <= S_RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            S_RESP: begin
               state     <= S_IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= S_IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_220066_lsu.sv
// Directed self-checking bench for ysyx_220066_lsu. A small bus responder
// process answers requests with a programmable stall; each test task drives
// a scenario and checks hand-computed results inline.
module tb_ysyx_220066_lsu;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [63:0] req_addr;
   logic [2:0]  req_op;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic        mem_req_wr;
   logic [63:0] mem_req_addr;
   logic [63:0] mem_req_wdata;
   logic [7:0]  mem_req_wmask;
   logic        mem_resp_valid;
   logic [63:0] mem_resp_rdata;
   logic        mem_resp_err;

   int checks = 0;
   int failures = 0;

   // Bus responder controls (written by the main process only)
   logic        bus_on = 1'b1;
   int          bus_stall = 0;
   logic [63:0] bus_rdata = '0;
   logic        bus_err = 1'b0;
   int          late_req = 0;

   // Bus responder state (written by the responder only)
   int          late_done = 0;
   int          hs_cnt = 0;
   int          mreq_cyc = 0;
   int          stab_bad = 0;
   int          stall_cnt = 0;
   logic        pend = 1'b0;
   logic        seen = 1'b0;
   logic [63:0] l_addr, l_wdata;
   logic [7:0]  l_mask;
   logic        l_wr;

   ysyx_220066_lsu #(.TIMEOUT_CYC(TO)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_wr         (req_wr),
      .req_addr       (req_addr),
      .req_op         (req_op),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_err       (resp_err),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_wr     (mem_req_wr),
      .mem_req_addr   (mem_req_addr),
      .mem_req_wdata  (mem_req_wdata),
      .mem_req_wmask  (mem_req_wmask),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_rdata (mem_resp_rdata),
      .mem_resp_err   (mem_resp_err)
   );

   always #5 clk = ~clk;

   // Bus model: drives on the falling edge, responds the cycle after a handshake
   initial begin
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_rdata = '0;
      mem_resp_err   = 1'b0;
      forever begin
         @(negedge clk);
         mem_resp_valid = 1'b0;
         mem_resp_err   = 1'b0;
         if (late_req != late_done) begin
            late_done      = late_req;
            mem_resp_valid = 1'b1;
            mem_resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
         end
         if (pend) begin
            pend = 1'b0;
            if (bus_on) begin
               mem_resp_valid = 1'b1;
               mem_resp_rdata = bus_rdata;
               mem_resp_err   = bus_err;
            end
         end
         mem_req_ready = 1'b0;
         if (mem_req_valid === 1'b1) begin
            mreq_cyc++;
            if (seen && (mem_req_addr !== l_addr || mem_req_wdata !== l_wdata ||
                         mem_req_wmask !== l_mask || mem_req_wr !== l_wr))
               stab_bad++;
            seen    = 1'b1;
            l_addr  = mem_req_addr;
            l_wdata = mem_req_wdata;
            l_mask  = mem_req_wmask;
            l_wr    = mem_req_wr;
            if (stall_cnt >= bus_stall) begin
               mem_req_ready = 1'b1;
               hs_cnt++;
               pend      = 1'b1;
               seen      = 1'b0;
               stall_cnt = 0;
            end else begin
               stall_cnt++;
            end
         end else begin
            seen      = 1'b0;
            stall_cnt = 0;
         end
      end
   end

   // Drive one request once the LSU is ready; capture the bus request one
   // cycle after acceptance and the response when it arrives (bounded).
   task automatic txn(input logic wr, input logic [63:0] addr, input logic [2:0] op,
                      input logic [63:0] wdata,
                      output logic q_valid, output logic [63:0] q_addr,
                      output logic [63:0] q_wdata, output logic [7:0] q_wmask,
                      output logic [63:0] r_rdata, output logic r_err, output int lat);
      int n;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = addr;
      req_op    = op;
      req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0;
      q_valid   = mem_req_valid;
      q_addr    = mem_req_addr;
      q_wdata   = mem_req_wdata;
      q_wmask   = mem_req_wmask;
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      r_rdata = resp_rdata;
      r_err   = resp_err;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
      checks++; if (resp_rdata !== 64'd0 || resp_err !== 1'b0) begin failures++; $display("FAIL reset_resp got=%h/%b exp=0/0", resp_rdata, resp_err); end
      checks++; if (mem_req_valid !== 1'b0 || mem_req_wmask !== 8'h00 || mem_req_addr !== 64'd0) begin
         failures++; $display("FAIL reset_bus got=%b/%h/%h exp=0/00/0", mem_req_valid, mem_req_wmask, mem_req_addr); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", req_ready); end
   endtask

   task automatic test_sb();
      logic qv, re; logic [63:0] qa, qd, rd; logic [7:0] qm; int lat;
      bus_rdata = 64'h1122_3344_5566_7788;
      txn(1'b1, 64'h8000_0003, 3'b000, 64'h0000_0000_0000_00AB, qv, qa, qd, qm, rd, re, lat);
      checks++; if (qv !== 1'b1) begin failures++; $display("FAIL sb_req_valid got=%b exp=1", qv); end
      checks++; if (qa !== 64'h8000_0000) begin failures++; $display("FAIL sb_addr got=%h exp=80000000", qa); end
      checks++; if (qm !== 8'h08) begin failures++; $display("FAIL sb_wmask got=%h exp=08", qm); end
      checks++; if (qd !== 64'hABAB_ABAB_ABAB_ABAB) begin failures++; $display("FAIL sb_wdata got=%h exp=abababababababab", qd); end
      checks++; if (lat !== 3) begin failures++; $display("FAIL sb_latency got=%0d exp=3", lat); end
      checks++; if (rd !== 64'd0 || re !== 1'b0) begin failures++; $display("FAIL sb_resp got=%h/%b exp=0/0", rd, re); end
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL sb_after got=%b/%b exp=0/1", resp_valid, req_ready); end
   endtask

   task automatic test_loads();
      logic qv, re; logic [63:0] qa, qd, rd; logic [7:0] qm; int lat;
      bus_rdata = 64'h8001_0000_0000_0000;
      txn(1'b0, 64'h8000_0006, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, qv, qa, qd, qm, rd, re, lat);
      checks++; if (qm !== 8'h00 || qa !== 64'h8000_0000) begin failures++; $display("FAIL lh_req got=%h/%h exp=00/80000000", qm, qa); end
      checks++; if (rd !== 64'hFFFF_FFFF_FFFF_8001 || re !== 1'b0) begin failures++; $display("FAIL lh_data got=%h/%b exp=ffffffffffff8001/0", rd, re); end
      txn(1'b0, 64'h8000_0006, 3'b101, 64'd0, qv, qa, qd, qm, rd, re, lat);
      checks++; if (rd !== 64'h0000_0000_0000_8001) begin failures++; $display("FAIL lhu_data got=%h exp=0000000000008001", rd); end
      txn(1'b0, 64'h8000_0007, 3'b000, 64'd0, qv, qa, qd, qm, rd, re, lat);
      checks++; if (rd !== 64'hFFFF_FFFF_FFFF_FF80) begin failures++; $display("FAIL lb_data got=%h exp=ffffffffffffff80", rd); end
      txn(1'b0, 64'h8000_0006, 3'b100, 64'd0, qv, qa, qd, qm, rd, re, lat);
      checks++; if (rd !== 64'h0000_0000_0000_0001) begin failures++; $display("FAIL lbu_data got=%h exp=1", rd); end
      txn(1'b0, 64'h8000_0004, 3'b110, 64'd0, qv, qa, qd, qm, rd, re, lat);
      checks++; if (rd !== 64'h0000_0000_8001_0000) begin failures++; $display("FAIL lwu_data got=%h exp=0000000080010000", rd); end
      txn(1'b0, 64'h8000_0000, 3'b011, 64'd0, qv, qa, qd, qm, rd, re, lat);
      checks++; if (rd !== 64'h8001_0000_0000_0000) begin failures++; $display("FAIL ld_data got=%h exp=8001000000000000", rd); end
      bus_rdata = 64'h0000_0000_0000_1234;
      bus_err   = 1'b1;
      txn(1'b0, 64'h8000_0001, 3'b100, 64'd0, qv, qa, qd, qm, rd, re, lat);
      bus_err   = 1'b0;
      checks++; if (rd !== 64'd0 || re !== 1'b1) begin failures++; $display("FAIL buserr_resp got=%h/%b exp=0/1", rd, re); end
   endtask

   task automatic test_stores();
      logic qv, re; logic [63:0] qa, qd, rd; logic [7:0] qm; int lat;
      txn(1'b1, 64'h8000_0008, 3'b111, 64'h0123_4567_89AB_CDEF, qv, qa, qd, qm, rd, re, lat);
      checks++; if (qm !== 8'hFF || qd !== 64'h0123_4567_89AB_CDEF || qa !== 64'h8000_0008) begin
         failures++; $display("FAIL sd_req got=%h/%h/%h exp=ff/0123456789abcdef/80000008", qm, qd, qa); end
      txn(1'b1, 64'h8000_0006, 3'b001, 64'h0000_0000_FFFF_1234, qv, qa, qd, qm, rd, re, lat);
      checks++; if (qm !== 8'hC0 || qd !== 64'h1234_1234_1234_1234) begin
         failures++; $display("FAIL sh_req got=%h/%h exp=c0/1234123412341234", qm, qd); end
   endtask

   task automatic test_stall();
      logic qv, re; logic [63:0] qa, qd, rd; logic [7:0] qm; int lat, hs0, mc0, sb0;
      hs0 = hs_cnt; mc0 = mreq_cyc; sb0 = stab_bad;
      bus_stall = 5;
      bus_rdata = 64'h8001_0000_0000_0000;
      txn(1'b0, 64'h8000_0004, 3'b010, 64'd0, qv, qa, qd, qm, rd, re, lat);
      bus_stall = 0;
      checks++; if (lat !== 8) begin failures++; $display("FAIL stall_latency got=%0d exp=8", lat); end
      checks++; if (hs_cnt - hs0 !== 1) begin failures++; $display("FAIL stall_handshakes got=%0d exp=1", hs_cnt - hs0); end
      checks++; if (mreq_cyc - mc0 !== 6) begin failures++; $display("FAIL stall_valid_cycles got=%0d exp=6", mreq_cyc - mc0); end
      checks++; if (stab_bad - sb0 !== 0) begin failures++; $display("FAIL stall_stable got=%0d exp=0", stab_bad - sb0); end
      checks++; if (rd !== 64'hFFFF_FFFF_8001_0000 || re !== 1'b0) begin failures++; $display("FAIL stall_lw_data got=%h/%b exp=ffffffff80010000/0", rd, re); end
   endtask

   task automatic test_timeout();
      logic qv, re; logic [63:0] qa, qd, rd; logic [7:0] qm; int lat;
      bus_on = 1'b0;
      txn(1'b0, 64'h8000_0010, 3'b011, 64'd0, qv, qa, qd, qm, rd, re, lat);
      checks++; if (lat !== TO + 2) begin failures++; $display("FAIL timeout_latency got=%0d exp=%0d", lat, TO + 2); end
      checks++; if (re !== 1'b1 || rd !== 64'd0) begin failures++; $display("FAIL timeout_resp got=%h/%b exp=0/1", rd, re); end
      #1 late_req++;
      bus_on = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL late_resp_ignored got=%b/%b exp=0/1", resp_valid, req_ready); end
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL late_resp_quiet got=%b/%b exp=0/0", resp_valid, mem_req_valid); end
   endtask

   task automatic test_rst_wait();
      int n, spurious;
      bus_on = 1'b0;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 64'h8000_0020; req_op = 3'b010;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
         failures++; $display("FAIL rst_wait_idle got=%b/%b/%b exp=1/0/0", req_ready, resp_valid, mem_req_valid); end
      spurious = 0;
      repeat (4) begin
         @(negedge clk);
         if (resp_valid !== 1'b0) spurious++;
      end
      checks++; if (spurious !== 0) begin failures++; $display("FAIL rst_wait_no_resp got=%0d exp=0", spurious); end
      bus_on = 1'b1;
   endtask

   task automatic test_back_to_back();
      logic qv, re; logic [63:0] qa, qd, rd; logic [7:0] qm; int lat;
      bus_rdata = 64'h00FF_0000_0000_0000;
      txn(1'b1, 64'h8000_0040, 3'b011, 64'h5555_AAAA_5555_AAAA, qv, qa, qd, qm, rd, re, lat);
      checks++; if (lat !== 3 || rd !== 64'd0) begin failures++; $display("FAIL b2b_store got=%0d/%h exp=3/0", lat, rd); end
      @(negedge clk);
      checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", req_ready); end
      txn(1'b0, 64'h8000_0046, 3'b000, 64'd0, qv, qa, qd, qm, rd, re, lat);
      checks++; if (lat !== 3 || rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL b2b_load got=%0d/%h exp=3/ffffffffffffffff", lat, rd); end
   endtask

   task automatic test_misalign();
      logic qv, re; logic [63:0] qa, qd, rd; logic [7:0] qm; int lat, mc0;
      mc0 = mreq_cyc;
`ifdef YSYX_220066_LSU_MISALIGN_EN
      txn(1'b1, 64'h8000_0002, 3'b010, 64'h1122_3344_DEAD_BEEF, qv, qa, qd, qm, rd, re, lat);
      checks++; if (lat !== 1 || re !== 1'b1 || rd !== 64'd0) begin
         failures++; $display("FAIL misalign_resp got=%0d/%b/%h exp=1/1/0", lat, re, rd); end
      repeat (3) @(negedge clk);
      checks++; if (mreq_cyc - mc0 !== 0) begin failures++; $display("FAIL misalign_no_bus got=%0d exp=0", mreq_cyc - mc0); end
`else
      txn(1'b1, 64'h8000_0002, 3'b010, 64'h1122_3344_DEAD_BEEF, qv, qa, qd, qm, rd, re, lat);
      checks++; if (qm !== 8'h0F || qd !== 64'hDEAD_BEEF_DEAD_BEEF || qa !== 64'h8000_0000) begin
         failures++; $display("FAIL unaligned_sw got=%h/%h/%h exp=0f/deadbeefdeadbeef/80000000", qm, qd, qa); end
      checks++; if (re !== 1'b0 || mreq_cyc - mc0 !== 1) begin failures++; $display("FAIL unaligned_sw_bus got=%b/%0d exp=0/1", re, mreq_cyc - mc0); end
      txn(1'b1, 64'h8000_0001, 3'b001, 64'h0000_0000_0000_BEEF, qv, qa, qd, qm, rd, re, lat);
      checks++; if (qm !== 8'h03) begin failures++; $display("FAIL unaligned_sh got=%h exp=03", qm); end
`endif
   endtask

   initial begin
      rst       = 1'b0;
      req_valid = 1'b0;
      req_wr    = 1'b0;
      req_addr  = '0;
      req_op    = '0;
      req_wdata = '0;
      test_reset();
      test_sb();
      test_loads();
      test_stores();
      test_stall();
      test_timeout();
      test_rst_wait();
      test_back_to_back();
      test_misalign();
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
